// File: rtl/ds_dac_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ds_dac_pkg : shared types and constants for the DAC controller   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ds_dac_pkg;

  localparam int                   DS_DATA_W    = 16;
  localparam logic [DS_DATA_W-1:0] MIDSCALE     = DS_DATA_W'(2**(DS_DATA_W-1)-1);
  localparam logic [7:0]           UNDERRUN_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } ds_ctrl_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == UNDERRUN_MAX) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ds_sample_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ds_sample_fifo : show-ahead synchronous sample FIFO with flush   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ds_sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk50m,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [c_AW-1:0]   wr_ptr_q;
  logic [c_AW-1:0]   rd_ptr_q;
  logic [c_AW:0]     count_q;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (count_q == (c_AW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign dout      = mem_q[rd_ptr_q];
  // A pop on an empty FIFO is dropped, so a simultaneous push is still stored.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk50m) begin
    if (w_do_push && !flush && !rst) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + c_AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + (c_AW+1)'(1);
        2'b01:   count_q <= count_q - (c_AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ds_dac_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ds_dac_ctrl : sample-rate controller with pop-free ramp start/stop|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ds_dac_ctrl
  import ds_dac_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                DIV_W      = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] RAMP_STEP  = 16'h0400
) (
  input  logic              clk50m,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] dac_din,
  output logic              dac_clk_enable,
  output logic              busy,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);

  localparam logic [DATA_W-1:0] c_MIDSCALE = {1'b0, {(DATA_W-1){1'b1}}};

  ds_ctrl_state_t    state_q;
  logic [DATA_W-1:0] dac_din_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [DIV_W-1:0]  rate_q;
  logic              underrun_q;
  logic [7:0]        underrun_cnt_q;

  logic              w_tick;
  logic              w_active;
  logic [DATA_W:0]   w_up_sum;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_flush;
  logic [DATA_W-1:0] w_fifo_dout;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  assign w_active     = (state_q == RAMP_UP) || (state_q == RUN);
  assign w_tick       = (state_q != IDLE) && (div_cnt_q == rate_q);
  assign w_up_sum     = {1'b0, dac_din_q} + {1'b0, RAMP_STEP};
  assign s_ready      = w_active && !w_fifo_full;
  assign w_fifo_push  = s_valid && s_ready;
  assign w_fifo_pop   = (state_q == RUN) && en && w_tick;
  assign w_fifo_flush = w_active && !en;

  assign dac_din        = dac_din_q;
  assign dac_clk_enable = (state_q != IDLE);
  assign busy           = (state_q != IDLE);
  assign underrun       = underrun_q;
  assign underrun_cnt   = underrun_cnt_q;

  ds_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk50m (clk50m),
    .rst    (rst),
    .push   (w_fifo_push),
    .pop    (w_fifo_pop),
    .flush  (w_fifo_flush),
    .din    (s_data),
    .dout   (w_fifo_dout),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty)
  );

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q        <= IDLE;
      dac_din_q      <= '0;
      div_cnt_q      <= '0;
      rate_q         <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      underrun_q <= 1'b0;
      if (state_q != IDLE) begin
        div_cnt_q <= w_tick ? '0 : div_cnt_q + DIV_W'(1);
      end
      case (state_q)
        IDLE: begin
          div_cnt_q <= '0;
          if (en) begin
            state_q        <= RAMP_UP;
            rate_q         <= rate_div;
            underrun_cnt_q <= '0;
          end
        end
        RAMP_UP: begin
          // Stop request wins over a coincident tick; the ramp continues from here.
          if (!en) begin
            state_q <= RAMP_DOWN;
          end else if (w_tick) begin
            if (w_up_sum >= {1'b0, c_MIDSCALE}) begin
              dac_din_q <= c_MIDSCALE;
              state_q   <= RUN;
            end else begin
              dac_din_q <= w_up_sum[DATA_W-1:0];
            end
          end
        end
        RUN: begin
          if (!en) begin
            state_q <= RAMP_DOWN;
          end else if (w_tick) begin
            if (!w_fifo_empty) begin
              dac_din_q <= w_fifo_dout;
            end else begin
              underrun_q     <= 1'b1;
              underrun_cnt_q <= sat_inc8(underrun_cnt_q);
            end
          end
        end
        RAMP_DOWN: begin
          if (w_tick) begin
            if (dac_din_q <= RAMP_STEP) begin
              dac_din_q <= '0;
              state_q   <= IDLE;
            end else begin
              dac_din_q <= dac_din_q - RAMP_STEP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ds_dac_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ds_dac_ctrl : directed vector bench for ds_dac_ctrl           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ds_dac_ctrl;

  logic        clk50m = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] rate_div = '0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] dac_din;
  logic        dac_clk_enable;
  logic        busy;
  logic        underrun;
  logic [7:0]  underrun_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk50m = ~clk50m;

  ds_dac_ctrl #(
    .DATA_W     (16),
    .DIV_W      (16),
    .FIFO_DEPTH (4),
    .RAMP_STEP  (16'h2000)
  ) dut (
    .clk50m         (clk50m),
    .rst            (rst),
    .en             (en),
    .rate_div       (rate_div),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .dac_din        (dac_din),
    .dac_clk_enable (dac_clk_enable),
    .busy           (busy),
    .underrun       (underrun),
    .underrun_cnt   (underrun_cnt)
  );

  typedef struct {
    bit          rst;
    bit          en;
    bit          sv;
    logic [15:0] data;
    logic [15:0] rate;
    int          n;
    logic [15:0] e_din;
    bit          e_ce;
    bit          e_busy;
    bit          e_rdy;
    bit          e_und;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  // Waits for dac_din to change; exp_cyc < 0 skips the latency check.
  task automatic wait_din(input string name, input logic [15:0] exp, input int exp_cyc);
    logic [15:0] prev;
    int          cyc;
    prev = dac_din;
    cyc  = 0;
    while (dac_din === prev && cyc < 64) begin
      step(1);
      cyc++;
    end
    chk({name, "_din"}, 32'(dac_din), 32'(exp));
    if (exp_cyc >= 0) chk({name, "_cyc"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    logic [15:0] pd [5];
    int          pulses;
    bit          held;

    //          rst en sv data      rate   n   din       ce busy rdy und
    vecs[0]  = '{1, 0, 0, 16'h0000, 16'd0, 3,  16'h0000, 0, 0,   0,  0};
    vecs[1]  = '{0, 0, 0, 16'h0000, 16'd0, 20, 16'h0000, 0, 0,   0,  0};
    vecs[2]  = '{0, 1, 0, 16'h0000, 16'd3, 1,  16'h0000, 1, 1,   1,  0};
    vecs[3]  = '{0, 1, 0, 16'h0000, 16'd0, 3,  16'h0000, 1, 1,   1,  0};
    vecs[4]  = '{0, 1, 0, 16'h0000, 16'd0, 1,  16'h2000, 1, 1,   1,  0};
    vecs[5]  = '{0, 1, 0, 16'h0000, 16'd0, 3,  16'h2000, 1, 1,   1,  0};
    vecs[6]  = '{0, 1, 0, 16'h0000, 16'd0, 1,  16'h4000, 1, 1,   1,  0};
    vecs[7]  = '{0, 1, 0, 16'h0000, 16'd0, 4,  16'h6000, 1, 1,   1,  0};
    vecs[8]  = '{0, 1, 0, 16'h0000, 16'd0, 4,  16'h7FFF, 1, 1,   1,  0};
    vecs[9]  = '{0, 1, 1, 16'h1000, 16'd0, 1,  16'h7FFF, 1, 1,   1,  0};
    vecs[10] = '{0, 1, 1, 16'h2000, 16'd0, 1,  16'h7FFF, 1, 1,   1,  0};
    vecs[11] = '{0, 1, 1, 16'h3000, 16'd0, 1,  16'h7FFF, 1, 1,   1,  0};
    vecs[12] = '{0, 1, 0, 16'h0000, 16'd0, 1,  16'h1000, 1, 1,   1,  0};
    vecs[13] = '{0, 1, 0, 16'h0000, 16'd0, 3,  16'h1000, 1, 1,   1,  0};
    vecs[14] = '{0, 1, 0, 16'h0000, 16'd0, 1,  16'h2000, 1, 1,   1,  0};
    vecs[15] = '{0, 1, 0, 16'h0000, 16'd0, 4,  16'h3000, 1, 1,   1,  0};
    vecs[16] = '{0, 1, 0, 16'h0000, 16'd0, 3,  16'h3000, 1, 1,   1,  0};
    vecs[17] = '{0, 1, 0, 16'h0000, 16'd0, 1,  16'h3000, 1, 1,   1,  1};
    vecs[18] = '{0, 1, 0, 16'h0000, 16'd0, 1,  16'h3000, 1, 1,   1,  0};

    // Reset, idle, ramp-up at rate 3 (later rate_div edits must be ignored), streaming.
    for (int i = 0; i < 19; i++) begin
      rst      = vecs[i].rst;
      en       = vecs[i].en;
      s_valid  = vecs[i].sv;
      s_data   = vecs[i].data;
      rate_div = vecs[i].rate;
      step(vecs[i].n);
      chk($sformatf("v%0d_din", i),  32'(dac_din),        32'(vecs[i].e_din));
      chk($sformatf("v%0d_ce", i),   32'(dac_clk_enable), 32'(vecs[i].e_ce));
      chk($sformatf("v%0d_busy", i), 32'(busy),           32'(vecs[i].e_busy));
      chk($sformatf("v%0d_rdy", i),  32'(s_ready),        32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_und", i),  32'(underrun),       32'(vecs[i].e_und));
    end
    chk("s1_ucnt1", 32'(underrun_cnt), 32'd1);

    // Sustained underrun: one pulse per 4-cycle tick, count saturates.
    pulses = 0;
    held   = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      step(1);
      if (underrun === 1'b1) pulses++;
      if (dac_din !== 16'h3000) held = 1'b0;
    end
    chk("und_pulses", 32'(pulses), 32'd300);
    chk("und_hold", 32'(held), 32'd1);
    chk("und_sat", 32'(underrun_cnt), 32'd255);

    // Stop from a non-midscale level.
    en = 1'b0;
    step(1);
    chk("stop1_busy", 32'(busy), 32'd1);
    chk("stop1_rdy", 32'(s_ready), 32'd0);
    wait_din("stop1_a", 16'h1000, 2);
    wait_din("stop1_b", 16'h0000, 4);
    chk("stop1_ce", 32'(dac_clk_enable), 32'd0);

    // Prefill during ramp-up, then stop at midscale: FIFO must be flushed.
    en = 1'b1; rate_div = 16'd3;
    step(1);
    s_valid = 1'b1; s_data = 16'hAAAA; step(1);
    s_data = 16'hBBBB; step(1);
    s_valid = 1'b0;
    wait_din("up2_a", 16'h2000, 2);
    wait_din("up2_b", 16'h4000, 4);
    wait_din("up2_c", 16'h6000, 4);
    wait_din("up2_d", 16'h7FFF, 4);
    chk("up2_rdy", 32'(s_ready), 32'd1);
    en = 1'b0;
    step(1);
    chk("dn2_din0", 32'(dac_din), 32'h7FFF);
    chk("dn2_rdy", 32'(s_ready), 32'd0);
    wait_din("dn2_a", 16'h5FFF, 3);
    en = 1'b1;
    step(2);
    chk("dn2_toggle", 32'(busy), 32'd1);
    en = 1'b0;
    wait_din("dn2_b", 16'h3FFF, 2);
    wait_din("dn2_c", 16'h1FFF, 4);
    wait_din("dn2_d", 16'h0000, 4);
    chk("dn2_ce", 32'(dac_clk_enable), 32'd0);
    step(3);
    chk("dn2_idle", 32'(busy), 32'd0);

    // Restart at rate 0: tick every cycle, first RUN tick must underrun.
    en = 1'b1; rate_div = 16'd0;
    step(1);
    step(1);
    chk("r0_first", 32'(dac_din), 32'h2000);
    step(3);
    chk("r0_mid", 32'(dac_din), 32'h7FFF);
    step(1);
    chk("r0_flushed", 32'(underrun), 32'd1);
    chk("r0_din", 32'(dac_din), 32'h7FFF);
    chk("r0_ucnt", 32'(underrun_cnt), 32'd1);
    en = 1'b0;
    step(5);
    chk("r0_stop", 32'(dac_din), 32'h0000);
    chk("r0_busy", 32'(busy), 32'd0);

    // Fill to full during ramp-up, order of playback, then mid-operation reset.
    pd[0] = 16'h1111; pd[1] = 16'h2222; pd[2] = 16'h3333; pd[3] = 16'h8123; pd[4] = 16'h9999;
    en = 1'b1; rate_div = 16'd5;
    step(1);
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = pd[k];
      step(1);
      chk($sformatf("fill%0d_rdy", k), 32'(s_ready), (k < 3) ? 32'd1 : 32'd0);
    end
    s_valid = 1'b0;
    wait_din("f_up_a", 16'h2000, 1);
    wait_din("f_up_b", 16'h4000, 6);
    wait_din("f_up_c", 16'h6000, 6);
    wait_din("f_up_d", 16'h7FFF, 6);
    for (int k = 0; k < 4; k++) begin
      wait_din($sformatf("f_pop%0d", k), pd[k], 6);
    end
    chk("f_rdy", 32'(s_ready), 32'd1);
    step(6);
    chk("f_und", 32'(underrun), 32'd1);
    chk("f_hold", 32'(dac_din), 32'h8123);
    rst = 1'b1;
    step(1);
    chk("mr_din", 32'(dac_din), 32'h0000);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ce", 32'(dac_clk_enable), 32'd0);
    chk("mr_rdy", 32'(s_ready), 32'd0);
    chk("mr_und", 32'(underrun), 32'd0);
    chk("mr_ucnt", 32'(underrun_cnt), 32'd0);
    rst = 1'b0; en = 1'b1; rate_div = 16'd0;
    step(1);
    chk("mr_restart", 32'(busy), 32'd1);
    step(4);
    chk("mr_up", 32'(dac_din), 32'h7FFF);
    step(1);
    chk("mr_empty", 32'(underrun), 32'd1);
    en = 1'b0;
    step(6);
    chk("mr_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
